qkd_pingpong_capture: RTL and testbench

- Parametrised N-bank capture buffer between the QKD receiver sample stream and the on-chip RAM s1 write ports.
- Generalises the fixed two-bank, 16-bit memory pair. It fills banks in round-robin order and closes a bank on full, `in_last` or `flush`.
- It publishes a per-bank full flag and length to the HPS reader, which returns banks via `release`.
- When every bank is full, it either backpressures the stream or drops samples and counts them.

---
 rtl/qkd_pingpong_capture.sv | 130 +++++++++++++
 tb/tb_qkd_pingpong_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qkd_pingpong_capture.sv
// N-bank round-robin capture buffer between the QKD sample stream and the RAM s1 write ports.
// Banks close on full, in_last or flush; the HPS reader hands them back through bank_release.
module qkd_pingpong_capture #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DEPTH        = 8192,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned DROP_ON_FULL = 0
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset,
  input  logic                            enable,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_last,
  input  logic                            flush,
  output logic [ADDR_W-1:0]               bank_address,
  output logic [DATA_W-1:0]               bank_writedata,
  output logic [DATA_W/8-1:0]             bank_byteenable,
  output logic [NUM_BANKS-1:0]            bank_chipselect,
  output logic                            bank_write,
  output logic                            bank_clken,
  output logic [NUM_BANKS-1:0]            bank_full,
  output logic [NUM_BANKS*(ADDR_W+1)-1:0] bank_len,
  input  logic [NUM_BANKS-1:0]            bank_release,
  output logic [2:0]                      active_bank,
  output logic [15:0]                     drop_count
);

  localparam int unsigned      LEN_W        = ADDR_W + 1;
  localparam logic [0:0]       ST_FILL      = 1'b0;
  localparam logic [0:0]       ST_WAIT_FREE = 1'b1;
  localparam logic [LEN_W-1:0] FULL_LEN     = LEN_W'(DEPTH);
  localparam logic [2:0]       LAST_BANK    = 3'(NUM_BANKS - 1);

  logic [0:0]           state;
  logic [ADDR_W-1:0]    wr_ptr;
  logic                 close_pend;
  logic [2:0]           close_bank;
  logic [LEN_W-1:0]     close_len_q;

  logic                 accept;
  logic                 fill_accept;
  logic                 drop_accept;
  logic                 close_now;
  logic [LEN_W-1:0]     ptr_ext;
  logic [LEN_W-1:0]     ptr_inc;
  logic [LEN_W-1:0]     close_len;
  logic [2:0]           next_bank;
  logic [7:0]           sel_active;
  logic [7:0]           sel_pend;
  logic [7:0]           full_nxt_pad;
  logic [NUM_BANKS-1:0] rel_eff;
  logic [NUM_BANKS-1:0] full_nxt;

  assign bank_clken = 1'b1;
  assign in_ready   = !reset_reset && enable && ((state == ST_FILL) || (DROP_ON_FULL != 0));

  always_comb begin
    accept      = in_valid && in_ready;
    fill_accept = accept && (state == ST_FILL);
    drop_accept = accept && (state == ST_WAIT_FREE);
    ptr_ext     = {1'b0, wr_ptr};
    ptr_inc     = ptr_ext + LEN_W'(1);
    close_len   = fill_accept ? ptr_inc : ptr_ext;
    close_now   = (state == ST_FILL) &&
                  (fill_accept ? ((ptr_inc == FULL_LEN) || in_last || flush)
                               : (flush && (wr_ptr != '0)));
    next_bank   = (active_bank == LAST_BANK) ? 3'd0 : active_bank + 3'd1;
    sel_active  = 8'd1 << active_bank;
    sel_pend    = close_pend ? (8'd1 << close_bank) : 8'd0;
    // A closed bank counts as busy during the cycle before its full flag is published,
    // so back-to-back short frames can never wrap onto it.
    rel_eff      = bank_release & bank_full;
    full_nxt     = (bank_full & ~rel_eff) | sel_pend[NUM_BANKS-1:0];
    full_nxt_pad = 8'(full_nxt);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state           <= ST_FILL;
      wr_ptr          <= '0;
      active_bank     <= '0;
      close_pend      <= 1'b0;
      close_bank      <= '0;
      close_len_q     <= '0;
      bank_write      <= 1'b0;
      bank_address    <= '0;
      bank_writedata  <= '0;
      bank_byteenable <= '0;
      bank_chipselect <= '0;
      bank_full       <= '0;
      bank_len        <= '0;
      drop_count      <= '0;
    end else begin
      bank_write      <= fill_accept;
      bank_byteenable <= fill_accept ? '1 : '0;
      bank_chipselect <= fill_accept ? sel_active[NUM_BANKS-1:0] : '0;
      if (fill_accept) begin
        bank_address   <= wr_ptr;
        bank_writedata <= in_data;
      end

      // Full flag trails the last write strobe by one cycle so the RAM already holds the data.
      bank_full <= full_nxt;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (sel_pend[b]) bank_len[b*LEN_W +: LEN_W] <= close_len_q;
      end
      close_pend <= close_now;
      if (close_now) begin
        close_bank  <= active_bank;
        close_len_q <= close_len;
      end

      if (close_now) begin
        wr_ptr      <= '0;
        active_bank <= next_bank;
        state       <= full_nxt_pad[next_bank] ? ST_WAIT_FREE : ST_FILL;
      end else if (fill_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end else if ((state == ST_WAIT_FREE) && !full_nxt_pad[active_bank]) begin
        state <= ST_FILL;
      end

      if (drop_accept && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_qkd_pingpong_capture.sv
// Bench for qkd_pingpong_capture: a 2-bank backpressure instance and a 3-bank 32-bit drop
// instance share one random stream and are compared each cycle against a bank-ownership model.
module tb_qkd_pingpong_capture;

  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = AW + 1;
  localparam int          DEPTH = 4;

  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic        rst;
  logic        enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        flush;
  logic [2:0]  rel;

  logic          bp_ready, bp_write, bp_clken;
  logic [AW-1:0] bp_addr;
  logic [15:0]   bp_wdata;
  logic [1:0]    bp_be, bp_cs, bp_full;
  logic [2*LW-1:0] bp_len;
  logic [2:0]    bp_act;
  logic [15:0]   bp_drop;

  logic          dr_ready, dr_write, dr_clken;
  logic [AW-1:0] dr_addr;
  logic [31:0]   dr_wdata;
  logic [3:0]    dr_be;
  logic [2:0]    dr_cs, dr_full;
  logic [3*LW-1:0] dr_len;
  logic [2:0]    dr_act;
  logic [15:0]   dr_drop;

  qkd_pingpong_capture #(
    .DATA_W(16), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_BANKS(2), .DROP_ON_FULL(0)
  ) u_bp (
    .clk_clk(clk_clk), .reset_reset(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(bp_ready), .in_data(in_data[15:0]), .in_last(in_last), .flush(flush),
    .bank_address(bp_addr), .bank_writedata(bp_wdata), .bank_byteenable(bp_be),
    .bank_chipselect(bp_cs), .bank_write(bp_write), .bank_clken(bp_clken),
    .bank_full(bp_full), .bank_len(bp_len), .bank_release(rel[1:0]),
    .active_bank(bp_act), .drop_count(bp_drop)
  );

  qkd_pingpong_capture #(
    .DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_BANKS(3), .DROP_ON_FULL(1)
  ) u_dr (
    .clk_clk(clk_clk), .reset_reset(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(dr_ready), .in_data(in_data), .in_last(in_last), .flush(flush),
    .bank_address(dr_addr), .bank_writedata(dr_wdata), .bank_byteenable(dr_be),
    .bank_chipselect(dr_cs), .bank_write(dr_write), .bank_clken(dr_clken),
    .bank_full(dr_full), .bank_len(dr_len), .bank_release(rel),
    .active_bank(dr_act), .drop_count(dr_drop)
  );

  logic          o_ready [2];
  logic          o_write [2];
  logic          o_clken [2];
  logic [AW-1:0] o_addr  [2];
  logic [31:0]   o_data  [2];
  logic [3:0]    o_be    [2];
  logic [2:0]    o_cs    [2];
  logic [2:0]    o_full  [2];
  logic [2:0]    o_act   [2];
  logic [15:0]   o_drop  [2];
  logic [LW-1:0] o_len   [2][3];

  assign o_ready[0] = bp_ready;             assign o_ready[1] = dr_ready;
  assign o_write[0] = bp_write;             assign o_write[1] = dr_write;
  assign o_clken[0] = bp_clken;             assign o_clken[1] = dr_clken;
  assign o_addr[0]  = bp_addr;              assign o_addr[1]  = dr_addr;
  assign o_data[0]  = {16'h0000, bp_wdata}; assign o_data[1]  = dr_wdata;
  assign o_be[0]    = {2'b00, bp_be};       assign o_be[1]    = dr_be;
  assign o_cs[0]    = {1'b0, bp_cs};        assign o_cs[1]    = dr_cs;
  assign o_full[0]  = {1'b0, bp_full};      assign o_full[1]  = dr_full;
  assign o_act[0]   = bp_act;               assign o_act[1]   = dr_act;
  assign o_drop[0]  = bp_drop;              assign o_drop[1]  = dr_drop;
  assign o_len[0][0] = bp_len[0*LW +: LW];
  assign o_len[0][1] = bp_len[1*LW +: LW];
  assign o_len[0][2] = '0;
  assign o_len[1][0] = dr_len[0*LW +: LW];
  assign o_len[1][1] = dr_len[1*LW +: LW];
  assign o_len[1][2] = dr_len[2*LW +: LW];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which banks the reader owns, how many words sit in the bank being
  // filled, and a closed bank that is handed to the reader one cycle later.
  int  nb    [2] = '{2, 3};
  bit  dropm [2] = '{1'b0, 1'b1};
  int  m_fill[2], m_act[2], m_drop[2];
  bit  m_wait[2];
  bit  m_owned[2][3];
  int  m_len[2][3];
  bit  m_pub[2];
  int  m_pub_bank[2], m_pub_len[2];
  bit  e_wr[2];
  int  e_addr[2], e_cs[2];
  logic [31:0] e_data[2];

  function automatic bit exp_ready(input int k);
    return !rst && enable && (!m_wait[k] || dropm[k]);
  endfunction

  task automatic model_step(input int k);
    bit acc;
    int n;
    if (rst) begin
      m_fill[k] = 0; m_act[k] = 0; m_wait[k] = 0; m_drop[k] = 0; m_pub[k] = 0;
      e_wr[k] = 0; e_addr[k] = 0; e_data[k] = '0; e_cs[k] = 0;
      for (int b = 0; b < 3; b++) begin
        m_owned[k][b] = 0;
        m_len[k][b]   = 0;
      end
      return;
    end
    acc     = in_valid && exp_ready(k);
    e_wr[k] = acc && !m_wait[k];
    e_cs[k] = e_wr[k] ? (1 << m_act[k]) : 0;
    if (e_wr[k]) begin
      e_addr[k] = m_fill[k];
      e_data[k] = (k == 0) ? {16'h0000, in_data[15:0]} : in_data;
    end
    for (int b = 0; b < nb[k]; b++) if (rel[b]) m_owned[k][b] = 0;
    if (m_pub[k]) begin
      m_owned[k][m_pub_bank[k]] = 1;
      m_len[k][m_pub_bank[k]]   = m_pub_len[k];
      m_pub[k] = 0;
    end
    if (m_wait[k]) begin
      if (acc && m_drop[k] < 65535) m_drop[k]++;
      if (!m_owned[k][m_act[k]]) m_wait[k] = 0;
    end else begin
      n = m_fill[k] + int'(acc);
      if (n == DEPTH || (acc && (in_last || flush)) || (!acc && flush && n > 0)) begin
        m_pub[k]      = 1;
        m_pub_bank[k] = m_act[k];
        m_pub_len[k]  = n;
        m_fill[k]     = 0;
        m_act[k]      = (m_act[k] + 1) % nb[k];
        m_wait[k]     = m_owned[k][m_act[k]];
      end else begin
        m_fill[k] = n;
      end
    end
  endtask

  task automatic check_outputs(input int k);
    int f;
    f = 0;
    for (int b = 0; b < nb[k]; b++) if (m_owned[k][b]) f |= (1 << b);
    check_eq($sformatf("bank_write[%0d]", k), 64'(o_write[k]), 64'(e_wr[k]));
    check_eq($sformatf("chipselect[%0d]", k), 64'(o_cs[k]), 64'(e_cs[k]));
    check_eq($sformatf("byteenable[%0d]", k), 64'(o_be[k]),
             64'(e_wr[k] ? ((k == 0) ? 3 : 15) : 0));
    check_eq($sformatf("address[%0d]", k), 64'(o_addr[k]), 64'(e_addr[k]));
    check_eq($sformatf("writedata[%0d]", k), 64'(o_data[k]), 64'(e_data[k]));
    check_eq($sformatf("clken[%0d]", k), 64'(o_clken[k]), 64'(1));
    check_eq($sformatf("bank_full[%0d]", k), 64'(o_full[k]), 64'(f));
    for (int b = 0; b < nb[k]; b++)
      check_eq($sformatf("bank_len[%0d][%0d]", k, b), 64'(o_len[k][b]), 64'(m_len[k][b]));
    check_eq($sformatf("active_bank[%0d]", k), 64'(o_act[k]), 64'(m_act[k]));
    check_eq($sformatf("drop_count[%0d]", k), 64'(o_drop[k]), 64'(m_drop[k]));
  endtask

  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("in_ready[%0d]", k), 64'(o_ready[k]), 64'(exp_ready(k)));
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk_clk);
    #1;
    for (int k = 0; k < 2; k++) check_outputs(k);
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit f,
                       input logic [2:0] r);
    in_valid = v; in_data = d; in_last = l; flush = f; rel = r;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    drive(0, 0, 0, 0, 3'b000);
    drive(0, 0, 0, 0, 3'b101);
    rst = 1'b0; enable = 1'b1;

    // Fill every bank back-to-back, then keep presenting words with nothing released.
    for (int i = 1; i <= 12; i++) drive(1, 32'(i), 0, 0, 3'b000);
    for (int i = 13; i <= 17; i++) drive(1, 32'(i), 0, 0, 3'b000);
    drive(1, 32'h18, 0, 0, 3'b001);
    for (int i = 0; i < 3; i++) drive(1, 32'h20 + 32'(i), 0, 0, 3'b000);
    drive(0, 0, 0, 0, 3'b111);
    drive(0, 0, 0, 0, 3'b111);
    drive(0, 0, 0, 0, 3'b000);

    // Short frame, flushed partial bank, empty flush, flush with accept.
    drive(1, 32'h40, 0, 0, 3'b000);
    drive(1, 32'h41, 1, 0, 3'b000);
    drive(0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 3; i++) drive(1, 32'h50 + 32'(i), 0, 0, 3'b000);
    drive(0, 0, 0, 1, 3'b000);
    drive(0, 0, 0, 1, 3'b000);
    drive(1, 32'h60, 0, 1, 3'b110);
    drive(0, 0, 0, 0, 3'b111);

    // Enable low holds the fill; flush still closes it.
    drive(1, 32'h70, 0, 0, 3'b000);
    enable = 1'b0;
    drive(1, 32'h71, 0, 0, 3'b000);
    drive(0, 0, 0, 1, 3'b000);
    enable = 1'b1;
    drive(0, 0, 0, 0, 3'b111);

    // Reset mid-bank discards the partial bank.
    drive(1, 32'h80, 0, 0, 3'b000);
    drive(1, 32'h81, 0, 0, 3'b000);
    rst = 1'b1;
    drive(1, 32'h82, 0, 0, 3'b011);
    rst = 1'b0;
    drive(1, 32'h83, 0, 0, 3'b000);

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 90);
      rst    = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 5,
            ($urandom_range(0, 99) < 20) ? 3'($urandom_range(1, 7)) : 3'b000);
    end

    // Long overflow run: the drop counter must stop at its ceiling.
    rst = 1'b1; enable = 1'b1;
    drive(0, 0, 0, 0, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 65560; i++) drive(1, $urandom, 0, 0, 3'b000);
    check_eq("drop_saturated", 64'(dr_drop), 64'(16'hFFFF));
    check_eq("dr_ready_when_full", 64'(dr_ready), 64'(1));
    check_eq("bp_ready_when_full", 64'(bp_ready), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
